// File: rtl/ram_pkg.sv
// Shared encodings for the sized data RAM: access sizes, direction and FSM states.
package ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

endpackage

// File: rtl/ram_load_align.sv
// Combinational load formatter: picks byte/half/word from a big-endian fetch,
// extends it, and flags size/alignment faults.
module ram_load_align
  import ram_pkg::*;
(
  input  logic [31:0] i_bytes,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data,
  output logic        o_fault
);

  // i_bytes[31:24] is Mem[A], so the addressed byte always sits in the top lane.
  always_comb begin
    o_data  = 32'd0;
    o_fault = 1'b0;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sign_ext & i_bytes[31]}}, i_bytes[31:24]};
      SZ_HALF: begin
        o_fault = i_addr_lo[0];
        o_data  = {{16{i_sign_ext & i_bytes[31]}}, i_bytes[31:16]};
      end
      SZ_WORD: begin
        o_fault = |i_addr_lo;
        o_data  = i_bytes;
      end
      default: o_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_ram_sized.sv
// Byte-addressed big-endian data RAM with sized loads/stores, req/busy/done
// handshake, WAIT_STATES extra cycles and fault on illegal accesses.
module data_ram_sized
  import ram_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        read_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam int         DEPTH     = 2**ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [7:0] Mem [0:DEPTH-1];

  state_t      r_state, w_next;
  logic [3:0]  r_wait;
  logic        r_rw, r_sext;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_din;

  logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [31:0]       w_fetch, w_load;
  logic              w_align_fault, w_range_fault, w_fault, w_wr_en;

  // Offsets wrap within the array, so a misaligned fetch stays in range; it is faulted anyway.
  assign w_a0    = r_addr[ADDR_W-1:0];
  assign w_a1    = w_a0 + ADDR_W'(1);
  assign w_a2    = w_a0 + ADDR_W'(2);
  assign w_a3    = w_a0 + ADDR_W'(3);
  assign w_fetch = {Mem[w_a0], Mem[w_a1], Mem[w_a2], Mem[w_a3]};

  assign w_range_fault = (r_addr >> ADDR_W) != 32'd0;
  assign w_fault       = w_align_fault | w_range_fault;
  assign w_wr_en       = reset_n && (r_state == ST_EXEC) && (r_rw == RW_WRITE) && !w_fault;

  ram_load_align u_align (
    .i_bytes    (w_fetch),
    .i_size     (r_size),
    .i_sign_ext (r_sext),
    .i_addr_lo  (r_addr[1:0]),
    .o_data     (w_load),
    .o_fault    (w_align_fault)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req) w_next = (WAIT_STATES > 0) ? ST_WAIT : ST_EXEC;
      ST_WAIT: if (r_wait == 4'd0) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_wait   <= 4'd0;
      r_rw     <= RW_READ;
      r_size   <= SZ_BYTE;
      r_sext   <= 1'b0;
      r_addr   <= 32'd0;
      r_din    <= 32'd0;
      data_out <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      done    <= 1'b0;
      case (r_state)
        ST_IDLE: if (req) begin
          r_rw   <= read_write;
          r_size <= size;
          r_sext <= sign_ext;
          r_addr <= address;
          r_din  <= data_in;
          r_wait <= WAIT_LOAD;
          busy   <= 1'b1;
        end
        ST_WAIT: if (r_wait != 4'd0) r_wait <= r_wait - 4'd1;
        ST_EXEC: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          fault    <= w_fault;
          data_out <= (w_fault || r_rw == RW_WRITE) ? 32'd0 : w_load;
        end
        default: ;
      endcase
    end
  end

  // Array is deliberately left out of reset; only the write enable is gated.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      case (r_size)
        SZ_BYTE: Mem[w_a0] <= r_din[7:0];
        SZ_HALF: begin
          Mem[w_a0] <= r_din[15:8];
          Mem[w_a1] <= r_din[7:0];
        end
        default: begin
          Mem[w_a0] <= r_din[31:24];
          Mem[w_a1] <= r_din[23:16];
          Mem[w_a2] <= r_din[15:8];
          Mem[w_a3] <= r_din[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_sized.sv
// Directed bench for data_ram_sized: one instance with no wait states, one with three.
module tb_data_ram_sized;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0, req0, rw0, sx0, busy0, done0, fault0;
  logic [1:0]  sz0;
  logic [31:0] a0, di0, do0;
  logic        rst_n3, req3, rw3, sx3, busy3, done3, fault3;
  logic [1:0]  sz3;
  logic [31:0] a3, di3, do3;

  int checks = 0;
  int errors = 0;

  data_ram_sized #(.ADDR_W(8), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset_n(rst_n0), .req(req0), .read_write(rw0), .size(sz0),
    .sign_ext(sx0), .address(a0), .data_in(di0), .data_out(do0),
    .busy(busy0), .done(done0), .fault(fault0));

  data_ram_sized #(.ADDR_W(8), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset_n(rst_n3), .req(req3), .read_write(rw3), .size(sz3),
    .sign_ext(sx3), .address(a3), .data_in(di3), .data_out(do3),
    .busy(busy3), .done(done3), .fault(fault3));

  // Raise req for one edge, then wait (bounded) for done; lat counts edges from raising req.
  task automatic access(input bit s3, input bit rw, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] dout, output logic flt, output int lat, output int bcnt);
    @(negedge clk);
    if (s3) begin req3 = 1; rw3 = rw; sz3 = sz; sx3 = sx; a3 = a; di3 = d; end
    else    begin req0 = 1; rw0 = rw; sz0 = sz; sx0 = sx; a0 = a; di0 = d; end
    lat = 0; bcnt = 0; dout = 32'hx; flt = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin req0 = 0; req3 = 0; end
      if (s3 ? done3 : done0) begin
        lat = i; dout = s3 ? do3 : do0; flt = s3 ? fault3 : fault0;
        break;
      end
      if (s3 ? busy3 : busy0) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n0 = 0; rst_n3 = 0;
    req0 = 0; rw0 = 0; sz0 = 0; sx0 = 0; a0 = 0; di0 = 0;
    req3 = 0; rw3 = 0; sz3 = 0; sx3 = 0; a3 = 0; di3 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy0, done0, fault0, do0} !== 35'd0) begin errors++;
      $display("FAIL reset_ws0: got %b%b%b %h, want 000 00000000", busy0, done0, fault0, do0); end
    checks++; if ({busy3, done3, fault3, do3} !== 35'd0) begin errors++;
      $display("FAIL reset_ws3: got %b%b%b %h, want 000 00000000", busy3, done3, fault3, do3); end
    for (int i = 0; i < 256; i++) begin
      u0.Mem[i] = (i < 16) ? 8'(i) : 8'h00;
      u3.Mem[i] = (i < 16) ? 8'(i) : 8'h00;
    end
    @(negedge clk); rst_n0 = 1; rst_n3 = 1;
  endtask

  task automatic test_word_reads();
    logic [31:0] d, exp_d; logic f; int l, b;
    for (int k = 0; k < 4; k++) begin
      exp_d = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      access(0, 0, 2'b10, 0, 32'(4*k), 32'h0, d, f, l, b);
      checks++; if (d !== exp_d || f !== 1'b0 || l != 2) begin errors++;
        $display("FAIL word_read@%0d: got %h fault=%b lat=%0d, want %h fault=0 lat=2", 4*k, d, f, l, exp_d); end
    end
  endtask

  task automatic test_sized_loads();
    logic [31:0] d; logic f; int l, b;
    u0.Mem[0] = 8'hB5; u0.Mem[2] = 8'hFF; u0.Mem[3] = 8'hD3;
    access(0, 0, 2'b00, 0, 32'd0, 32'h0, d, f, l, b);
    checks++; if (d !== 32'h000000B5 || f !== 1'b0) begin errors++;
      $display("FAIL byte_zext: got %h fault=%b, want 000000b5 fault=0", d, f); end
    access(0, 0, 2'b00, 1, 32'd0, 32'h0, d, f, l, b);
    checks++; if (d !== 32'hFFFFFFB5 || f !== 1'b0) begin errors++;
      $display("FAIL byte_sext: got %h fault=%b, want ffffffb5 fault=0", d, f); end
    access(0, 0, 2'b01, 1, 32'd2, 32'h0, d, f, l, b);
    checks++; if (d !== 32'hFFFFFFD3 || f !== 1'b0) begin errors++;
      $display("FAIL half_sext: got %h fault=%b, want ffffffd3 fault=0", d, f); end
    access(0, 0, 2'b01, 0, 32'd2, 32'h0, d, f, l, b);
    checks++; if (d !== 32'h0000FFD3 || f !== 1'b0) begin errors++;
      $display("FAIL half_zext: got %h fault=%b, want 0000ffd3 fault=0", d, f); end
  endtask

  task automatic test_writes();
    logic [31:0] d; logic f; int l, b;
    u0.Mem[0] = 8'h00; u0.Mem[2] = 8'h02; u0.Mem[3] = 8'h03;
    access(0, 1, 2'b00, 0, 32'd0, 32'h000000B5, d, f, l, b);
    checks++; if (d !== 32'h0 || f !== 1'b0 || l != 2) begin errors++;
      $display("FAIL byte_write: got dout=%h fault=%b lat=%0d, want 0 0 2", d, f, l); end
    access(0, 1, 2'b01, 0, 32'd2, 32'h0000FFD3, d, f, l, b);
    access(0, 1, 2'b01, 0, 32'd4, 32'h0000FFD3, d, f, l, b);
    access(0, 1, 2'b10, 0, 32'd8, 32'hE35D8AC5, d, f, l, b);
    access(0, 0, 2'b10, 0, 32'd0, 32'h0, d, f, l, b);
    checks++; if (d !== 32'hB501FFD3) begin errors++;
      $display("FAIL readback@0: got %h, want b501ffd3", d); end
    access(0, 0, 2'b10, 0, 32'd4, 32'h0, d, f, l, b);
    checks++; if (d !== 32'hFFD30607) begin errors++;
      $display("FAIL readback@4: got %h, want ffd30607", d); end
    access(0, 0, 2'b10, 0, 32'd8, 32'h0, d, f, l, b);
    checks++; if (d !== 32'hE35D8AC5) begin errors++;
      $display("FAIL readback@8: got %h, want e35d8ac5", d); end
    access(0, 1, 2'b10, 0, 32'h000000FC, 32'hA1B2C3D4, d, f, l, b);
    access(0, 0, 2'b00, 1, 32'h000000FF, 32'h0, d, f, l, b);
    checks++; if (d !== 32'hFFFFFFD4 || f !== 1'b0) begin errors++;
      $display("FAIL top_byte: got %h fault=%b, want ffffffd4 fault=0", d, f); end
    access(0, 0, 2'b10, 0, 32'h000000FC, 32'h0, d, f, l, b);
    checks++; if (d !== 32'hA1B2C3D4 || f !== 1'b0) begin errors++;
      $display("FAIL top_word: got %h fault=%b, want a1b2c3d4 fault=0", d, f); end
  endtask

  task automatic test_faults();
    logic [31:0] d; logic f; int l, b;
    access(0, 0, 2'b01, 0, 32'd1, 32'h0, d, f, l, b);
    checks++; if (d !== 32'h0 || f !== 1'b1 || l != 2) begin errors++;
      $display("FAIL half_misalign: got %h fault=%b lat=%0d, want 0 fault=1 lat=2", d, f, l); end
    access(0, 1, 2'b10, 0, 32'd6, 32'h11223344, d, f, l, b);
    checks++; if (f !== 1'b1) begin errors++;
      $display("FAIL word_misalign: fault=%b, want 1", f); end
    access(0, 0, 2'b10, 0, 32'd4, 32'h0, d, f, l, b);
    checks++; if (d !== 32'hFFD30607 || f !== 1'b0) begin errors++;
      $display("FAIL no_write@4: got %h fault=%b, want ffd30607 fault=0", d, f); end
    access(0, 0, 2'b10, 0, 32'd8, 32'h0, d, f, l, b);
    checks++; if (d !== 32'hE35D8AC5) begin errors++;
      $display("FAIL no_write@8: got %h, want e35d8ac5", d); end
    access(0, 0, 2'b11, 0, 32'd0, 32'h0, d, f, l, b);
    checks++; if (d !== 32'h0 || f !== 1'b1) begin errors++;
      $display("FAIL size_illegal: got %h fault=%b, want 0 fault=1", d, f); end
    access(0, 0, 2'b00, 0, 32'h00000100, 32'h0, d, f, l, b);
    checks++; if (d !== 32'h0 || f !== 1'b1) begin errors++;
      $display("FAIL out_of_range: got %h fault=%b, want 0 fault=1", d, f); end
    access(0, 0, 2'b00, 0, 32'd1, 32'h0, d, f, l, b);
    checks++; if (d !== 32'h00000001 || f !== 1'b0) begin errors++;
      $display("FAIL fault_clear: got %h fault=%b, want 00000001 fault=0", d, f); end
  endtask

  task automatic test_handshake();
    logic [31:0] d; logic f; int l, b;
    access(1, 0, 2'b10, 0, 32'd0, 32'h0, d, f, l, b);
    checks++; if (d !== 32'h00010203 || l != 5 || b != 4) begin errors++;
      $display("FAIL ws3_latency: got %h lat=%0d busy=%0d, want 00010203 lat=5 busy=4", d, l, b); end
  endtask

  task automatic test_req_while_busy();
    logic [31:0] d; logic f; int l, b, nd;
    @(negedge clk); req3 = 1; rw3 = 1; sz3 = 2'b10; a3 = 32'd16; di3 = 32'h11223344;
    @(posedge clk); #1 req3 = 0;
    nd = 0;
    @(negedge clk); req3 = 1; a3 = 32'd20; di3 = 32'h55667788;
    @(posedge clk); #1 req3 = 0;
    if (done3) nd++;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (done3) nd++; end
    checks++; if (nd != 1) begin errors++;
      $display("FAIL busy_req_dones: got %0d done pulses, want 1", nd); end
    access(1, 0, 2'b10, 0, 32'd20, 32'h0, d, f, l, b);
    checks++; if (d !== 32'h0 || l != 5) begin errors++;
      $display("FAIL busy_req_nowrite: got %h lat=%0d, want 00000000 lat=5", d, l); end
    access(1, 0, 2'b10, 0, 32'd16, 32'h0, d, f, l, b);
    checks++; if (d !== 32'h11223344) begin errors++;
      $display("FAIL busy_req_first: got %h, want 11223344", d); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [31:0] dv;
    d1 = 0; d2 = 0; dv = 32'h0;
    @(negedge clk); req3 = 1; rw3 = 0; sz3 = 2'b10; sx3 = 0; a3 = 32'd4;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (done3) begin
        if (d1 == 0) begin d1 = i; dv = do3; end
        else if (d2 == 0) begin d2 = i; req3 = 0; end
      end
    end
    req3 = 0;
    repeat (8) @(posedge clk);
    checks++; if (d1 != 5 || d2 != 10 || dv !== 32'h04050607) begin errors++;
      $display("FAIL back_to_back: got done@%0d,%0d data %h, want 5,10 04050607", d1, d2, dv); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic f; int l, b, nd;
    @(negedge clk); req3 = 1; rw3 = 1; sz3 = 2'b10; a3 = 32'd12; di3 = 32'hDEADBEEF;
    @(posedge clk); #1 req3 = 0;
    @(posedge clk);
    @(negedge clk); rst_n3 = 0;
    @(posedge clk); #1;
    checks++; if ({busy3, done3, fault3, do3} !== 35'd0) begin errors++;
      $display("FAIL mid_reset_outs: got %b%b%b %h, want 000 00000000", busy3, done3, fault3, do3); end
    @(negedge clk); rst_n3 = 1;
    nd = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (done3) nd++; end
    checks++; if (nd != 0) begin errors++;
      $display("FAIL mid_reset_done: got %0d done pulses, want 0", nd); end
    access(1, 0, 2'b10, 0, 32'd12, 32'h0, d, f, l, b);
    checks++; if (d !== 32'h0C0D0E0F || f !== 1'b0 || l != 5) begin errors++;
      $display("FAIL mid_reset_mem: got %h fault=%b lat=%0d, want 0c0d0e0f 0 5", d, f, l); end
  endtask

  initial begin
    test_reset();
    test_word_reads();
    test_sized_loads();
    test_writes();
    test_faults();
    test_handshake();
    test_req_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
